posit_add_arbiter: RTL
======================

// Module: posit_add_arbiter
// PURPOSE
//  Shares one PositAdd datapath among NUM_REQ requesters (e.g. HPS-fed PIO channels, local engines).
//  Round-robin arbitration, one issue per cycle max, ADD_LATENCY pipeline tracking.
//  Results land in a credit-protected response FIFO, tagged with requester id.
//  Sits between the requester fabric and PositAdd; PositAdd operand and result ports connect through io_add_*.
// PARAMETERS
//  NBITS        32  posit word width; matches PositAdd io_num1/io_num2/io_out
//  NUM_REQ       4  number of requesters, 2..8; IDW = clog2(NUM_REQ)
//  ADD_LATENCY   1  cycles from io_add_valid to io_add_out valid, 0..8 (0 = same cycle)
//  RESP_DEPTH    4  response FIFO entries, >=1; also the max outstanding op count
// PORTS
//  clock          in   1              single clock
//  reset          in   1              synchronous, active-high
//  io_req_valid   in   NUM_REQ        per-requester op valid
//  io_req_ready   out  NUM_REQ        per-requester accept, one-hot or zero
//  io_req_num1    in   NUM_REQ*NBITS  packed operand A; requester i at [i*NBITS +: NBITS]
//  io_req_num2    in   NUM_REQ*NBITS  packed operand B
//  io_add_valid   out  1              op issued to the adder this cycle
//  io_add_num1    out  NBITS          to PositAdd io_num1
//  io_add_num2    out  NBITS          to PositAdd io_num2
//  io_add_out     in   NBITS          from PositAdd io_out
//  io_resp_valid  out  1              FIFO head valid
//  io_resp_ready  in   1              consumer accepts head
//  io_resp_data   out  NBITS          sum
//  io_resp_id     out  IDW            originating requester
//  io_busy        out  1              outstanding != 0
// BEHAVIOUR
//  - Reset: clears rr pointer to NUM_REQ-1 (req 0 wins first), pipeline, FIFO, counters. In-flight results are dropped.
//    During reset: io_req_ready=0, io_add_valid=0, io_resp_valid=0, io_busy=0.
//  - outstanding = ops in pipeline + FIFO count. can_issue = (outstanding < RESP_DEPTH).
//    outstanding is a register value; a pop frees its credit the following cycle, never the same cycle.
//  - Arbitration: grant = first valid requester strictly after the rr pointer, wrapping modulo NUM_REQ.
//    On issue, the pointer becomes the granted index. No valid -> pointer holds.
//  - Issue: io_req_ready[g] = can_issue & io_req_valid[g], combinational. Requesters must not make valid depend on ready.
//    io_add_valid equals the issue condition. io_add_num1/num2 = granted operands, else 0.
//  - Tracking: a shift register of ADD_LATENCY stages holding {valid, id}. At the last stage (or the issue cycle when
//    ADD_LATENCY=0), io_add_out and id are pushed into the FIFO. The adder is treated as a fixed-latency pipeline with no stall.
//  - FIFO: first-word-fall-through from registered storage. A push into an empty FIFO is visible the next cycle (no bypass).
//    Pop = io_resp_valid & io_resp_ready. Push and pop in the same cycle are legal.
//    Overflow is impossible by credit; an assertion flags a push while full.
//  - Data is held stable while io_resp_valid=1 and io_resp_ready=0. Sums are not reordered: issue order = response order.
//  - Arithmetic: pointer and FIFO pointers wrap modulo the size. outstanding is clog2(RESP_DEPTH+1) bits and saturates nowhere.
// CONFIGURATION
//  POSIT_ARB_STATS_EN defined: adds outputs io_stat_issued[31:0] and io_stat_stall[31:0].
//    io_stat_issued counts issues.
//    io_stat_stall counts cycles with any io_req_valid=1 and can_issue=0.
//    Both clear on reset and wrap at 2^32.
//  POSIT_ARB_STATS_EN undefined: those ports and counters are absent; all other behaviour is identical.
// TESTING  (NBITS=32, es=2; 1.0=0x40000000, 2.0=0x48000000, 0.5=0x38000000)
//  1. Reset held 3 cycles with all req valid=1 -> ready=0, add_valid=0, resp_valid=0 throughout.
//     After release, req0 is granted first.
//  2. req1 alone, 0x40000000+0x40000000, ADD_LATENCY=1, resp_ready=1 -> issue at T, resp_valid at T+2,
//     data 0x48000000, id 1, io_busy 1 from T+1 to T+2.
//  3. All 4 valid continuously, resp_ready=1 -> grants 0,1,2,3,0,... one per cycle.
//     Ids return in the same order; no requester is starved.
//  4. resp_ready=0, req0 streams ops -> exactly RESP_DEPTH=4 issues, then ready=0.
//     Raise resp_ready for 1 cycle -> one pop, and exactly one further issue starts the cycle after.
//  5. Reset asserted with 2 ops in the pipeline and 2 in the FIFO -> the next cycle has resp_valid=0 and busy=0.
//     No stale response ever appears.
//  6. POSIT_ARB_STATS_EN, run scenario 4 for 10 cycles -> io_stat_issued=4, io_stat_stall=6.

Source files
------------

// File: rtl/posit_add_arbiter.sv
// rtl/posit_add_arbiter.sv - round-robin arbiter sharing one PositAdd pipeline, id-tagged credit-protected response FIFO
// Optional POSIT_ARB_STATS_EN adds io_stat_issued / io_stat_stall counters.
module posit_add_arbiter #(
    parameter int NBITS       = 32,
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 1,
    parameter int RESP_DEPTH  = 4,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       io_req_valid,
    output logic [NUM_REQ-1:0]       io_req_ready,
    input  logic [NUM_REQ*NBITS-1:0] io_req_num1,
    input  logic [NUM_REQ*NBITS-1:0] io_req_num2,
    output logic                     io_add_valid,
    output logic [NBITS-1:0]         io_add_num1,
    output logic [NBITS-1:0]         io_add_num2,
    input  logic [NBITS-1:0]         io_add_out,
    output logic                     io_resp_valid,
    input  logic                     io_resp_ready,
    output logic [NBITS-1:0]         io_resp_data,
    output logic [IDW-1:0]           io_resp_id,
`ifdef POSIT_ARB_STATS_EN
    output logic [31:0]              io_stat_issued,
    output logic [31:0]              io_stat_stall,
`endif
    output logic                     io_busy
);

    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    logic [IDW-1:0]   r_rr_ptr;
    logic [CW-1:0]    r_outstanding;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [NBITS-1:0] r_mem_data [RESP_DEPTH];
    logic [IDW-1:0]   r_mem_id   [RESP_DEPTH];

    logic             w_any;
    logic [IDW-1:0]   w_grant;
    logic [IDW-1:0]   w_idx;
    logic             w_can_issue;
    logic             w_issue;
    logic             w_push;
    logic [IDW-1:0]   w_push_id;
    logic             w_pop;
    logic [NBITS-1:0] w_num1 [NUM_REQ];
    logic [NBITS-1:0] w_num2 [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_num1[g] = io_req_num1[g*NBITS +: NBITS];
        assign w_num2[g] = io_req_num2[g*NBITS +: NBITS];
    end

    // Scan downward so the nearest valid requester after the pointer is the last one written.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (io_req_valid[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    assign w_can_issue = !reset && (r_outstanding < CW'(RESP_DEPTH));
    assign w_issue     = w_can_issue && w_any;

    always_comb begin
        io_req_ready = '0;
        if (w_issue) io_req_ready[w_grant] = 1'b1;
    end

    assign io_add_valid = w_issue;
    assign io_add_num1  = w_issue ? w_num1[w_grant] : '0;
    assign io_add_num2  = w_issue ? w_num2[w_grant] : '0;

    if (ADD_LATENCY == 0) begin : g_lat0
        assign w_push    = w_issue;
        assign w_push_id = w_grant;
    end else begin : g_pipe
        logic [ADD_LATENCY-1:0] r_pipe_v;
        logic [IDW-1:0]         r_pipe_id [ADD_LATENCY];

        always_ff @(posedge clock) begin
            if (reset) begin
                r_pipe_v <= '0;
            end else begin
                r_pipe_v[0] <= w_issue;
                for (int i = 1; i < ADD_LATENCY; i++) r_pipe_v[i] <= r_pipe_v[i-1];
            end
            r_pipe_id[0] <= w_grant;
            for (int i = 1; i < ADD_LATENCY; i++) r_pipe_id[i] <= r_pipe_id[i-1];
        end

        assign w_push    = r_pipe_v[ADD_LATENCY-1];
        assign w_push_id = r_pipe_id[ADD_LATENCY-1];
    end

    assign io_resp_valid = !reset && (r_count != '0);
    assign io_resp_data  = r_mem_data[r_rd_ptr];
    assign io_resp_id    = r_mem_id[r_rd_ptr];
    assign w_pop         = io_resp_valid && io_resp_ready;
    assign io_busy       = !reset && (r_outstanding != '0);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= io_add_out;
            r_mem_id[r_wr_ptr]   <= w_push_id;
        end
    end

    // Credits cover pipeline plus FIFO, so a push only moves an op between the two and leaves outstanding alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr      <= IDW'(NUM_REQ - 1);
            r_outstanding <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            if (w_issue) r_rr_ptr <= w_grant;
            case ({w_issue, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(RESP_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(RESP_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(w_push && (r_count == CW'(RESP_DEPTH))));

`ifdef POSIT_ARB_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_issue) r_stat_issued <= r_stat_issued + 32'd1;
            if ((|io_req_valid) && !w_can_issue) r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign io_stat_issued = r_stat_issued;
    assign io_stat_stall  = r_stat_stall;
`endif

endmodule
